// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_arbiter
//  Description : Two-channel round-robin arbiter placed directly upstream of
//                a 2:1 mux. Produces the registered mux select (0 = channel 1,
//                1 = channel 2) and forwards the granted channel's beats
//                through a registered valid/ready output stage. A burst limit
//                bounds how many consecutive beats one channel may take while
//                the other channel is requesting.
//  Ports       : clk      - clock, all state on rising edge
//                rst_n    - asynchronous active-low reset
//                d1/v1/r1 - channel 1 data / valid / ready
//                d2/v2/r2 - channel 2 data / valid / ready
//                sel      - registered mux select / current grant
//                y        - registered output data
//                y_ch     - source channel of y (0 = ch1, 1 = ch2)
//                y_valid  - output valid
//                y_ready  - downstream ready
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d1,
    input  logic             v1,
    output logic             r1,
    input  logic [WIDTH-1:0] d2,
    input  logic             v2,
    output logic             r2,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_ch,
    output logic             y_valid,
    input  logic             y_ready
);

    // Counter only has to reach MAX_BURST, so this width never overflows
    // on the increment used below.
    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G2   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   burst_cnt_q, burst_cnt_d;
    logic               last_q,      last_d;     // 0 = ch1 served last, 1 = ch2
    logic               sel_q,       sel_d;
    logic [WIDTH-1:0]   y_q,         y_d;
    logic               y_ch_q,      y_ch_d;
    logic               y_valid_q,   y_valid_d;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic               w_can_load;
    logic               w_xfer1;
    logic               w_xfer2;
    logic [CNT_W-1:0]   w_cnt_inc;

    // Output register can take a beat when empty or being drained this edge.
    assign w_can_load = !y_valid_q || y_ready;

    // Ready depends only on state and the output stage, never on v1/v2.
    assign r1 = (state_q == G1) && w_can_load;
    assign r2 = (state_q == G2) && w_can_load;

    assign w_xfer1   = v1 && r1;
    assign w_xfer2   = v2 && r2;
    assign w_cnt_inc = burst_cnt_q + 1'b1;

    // ------------------------------------------------------------------
    // Grant FSM: next-state, burst counter and round-robin history
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;

        case (state_q)
            IDLE: begin
                // No beats are accepted here; the grant takes effect next cycle.
                if (v1 && v2) begin
                    state_d = last_q ? G1 : G2;
                end else if (v1) begin
                    state_d = G1;
                end else if (v2) begin
                    state_d = G2;
                end
            end

            G1: begin
                if (w_xfer1) begin
                    if (w_cnt_inc == CNT_MAX) begin
                        // Burst limit hit: hand over if ch2 waits, otherwise wrap.
                        burst_cnt_d = '0;
                        last_d      = 1'b0;
                        if (v2) begin
                            state_d = G2;
                        end
                    end else begin
                        burst_cnt_d = w_cnt_inc;
                    end
                end else if (!v1) begin
                    burst_cnt_d = '0;
                    last_d      = 1'b0;
                    state_d     = v2 ? G2 : IDLE;
                end
                // v1 held but blocked by the output stage: everything holds.
            end

            G2: begin
                if (w_xfer2) begin
                    if (w_cnt_inc == CNT_MAX) begin
                        burst_cnt_d = '0;
                        last_d      = 1'b1;
                        if (v1) begin
                            state_d = G1;
                        end
                    end else begin
                        burst_cnt_d = w_cnt_inc;
                    end
                end else if (!v2) begin
                    burst_cnt_d = '0;
                    last_d      = 1'b1;
                    state_d     = v1 ? G1 : IDLE;
                end
            end

            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Select follows the grant being entered; it holds through IDLE so the
    // mux keeps pointing at the last served channel.
    always_comb begin
        sel_d = sel_q;
        case (state_d)
            G1:      sel_d = 1'b0;
            G2:      sel_d = 1'b1;
            default: sel_d = sel_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    always_comb begin
        y_d       = y_q;
        y_ch_d    = y_ch_q;
        y_valid_d = y_valid_q;

        if (w_xfer1) begin
            y_d       = d1;
            y_ch_d    = 1'b0;
            y_valid_d = 1'b1;
        end else if (w_xfer2) begin
            y_d       = d2;
            y_ch_d    = 1'b1;
            y_valid_d = 1'b1;
        end else if (y_ready) begin
            y_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            last_q      <= 1'b1;    // ch1 wins the first tie
            sel_q       <= 1'b0;
            y_q         <= '0;
            y_ch_q      <= 1'b0;
            y_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            y_q         <= y_d;
            y_ch_q      <= y_ch_d;
            y_valid_q   <= y_valid_d;
        end
    end

    assign sel     = sel_q;
    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;

endmodule
`default_nettype wire
